// File: rtl/rtu_req_arbiter.sv
// rtu_req_arbiter: shares the single RTU lookup engine among g_num_ports
// request channels (endpoints + NIC). Requests are granted round-robin, one
// lookup is outstanding at a time, and the engine response is routed back to
// the port that issued it.
//
// Optional feature: define RTU_ARB_TIMEOUT_EN to build the response watchdog
// (g_timeout cycles in WAIT_RSP, then a drop response to the requester).
//
// Ports:
//   clk_sys_i, rst_n_i        system clock, synchronous active-low reset
//   req_valid_i/req_data_i    per-port pending request, packed per-port slices
//   req_ack_o                 one-cycle pulse when a port's request is captured
//   eng_valid_o/eng_data_o/eng_port_o, eng_ready_i   request channel to engine
//   rsp_valid_i/rsp_port_i/rsp_data_i               response from engine
//   rsp_valid_o/rsp_data_o/rsp_drop_o               per-port response delivery
//   err_o                     one-cycle pulse on unexpected or mis-tagged response
module rtu_req_arbiter #(
  parameter int unsigned g_num_ports = 7,
  parameter int unsigned g_req_width = 112,
  parameter int unsigned g_rsp_width = 40,
  parameter int unsigned g_timeout   = 1023
) (
  input  logic                             clk_sys_i,
  input  logic                             rst_n_i,
  input  logic [g_num_ports-1:0]           req_valid_i,
  input  logic [g_num_ports*g_req_width-1:0] req_data_i,
  output logic [g_num_ports-1:0]           req_ack_o,
  output logic                             eng_valid_o,
  output logic [g_req_width-1:0]           eng_data_o,
  output logic [$clog2(g_num_ports)-1:0]   eng_port_o,
  input  logic                             eng_ready_i,
  input  logic                             rsp_valid_i,
  input  logic [$clog2(g_num_ports)-1:0]   rsp_port_i,
  input  logic [g_rsp_width-1:0]           rsp_data_i,
  output logic [g_num_ports-1:0]           rsp_valid_o,
  output logic [g_rsp_width-1:0]           rsp_data_o,
  output logic                             rsp_drop_o,
  output logic                             err_o
);

  localparam int unsigned P = $clog2(g_num_ports);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t                 state;
  logic [P-1:0]           last;

  logic                   gnt_hit;
  logic [P-1:0]           gnt_idx;
  int unsigned            cand;
  logic [P-1:0]           cand_idx;
  logic [g_req_width-1:0] req_arr [g_num_ports];
  logic                   rsp_match;

  // Unpack the request bus into per-port slices.
  for (genvar g = 0; g < g_num_ports; g++) begin : g_unpack
    assign req_arr[g] = req_data_i[g*g_req_width +: g_req_width];
  end

  // Round-robin select: first pending port searching cyclically from last+1.
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= g_num_ports; i++) begin
      cand = 32'(last) + i;
      if (cand >= g_num_ports) cand = cand - g_num_ports;
      cand_idx = P'(cand);
      if (!gnt_hit && req_valid_i[cand_idx]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign rsp_match = rsp_valid_i && (rsp_port_i == eng_port_o);

`ifdef RTU_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(g_timeout + 1) > 10) ? $clog2(g_timeout + 1) : 10;
  localparam logic [CW-1:0] EXPIRE = CW'(g_timeout - 1);
  logic [CW-1:0] wdog;
`endif

  // Arbitration / issue / response-routing FSM with registered outputs.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      last        <= P'(g_num_ports - 1);
      req_ack_o   <= '0;
      eng_valid_o <= 1'b0;
      eng_data_o  <= '0;
      eng_port_o  <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_drop_o  <= 1'b0;
      err_o       <= 1'b0;
`ifdef RTU_ARB_TIMEOUT_EN
      wdog        <= '0;
`endif
    end else begin
      req_ack_o   <= '0;
      rsp_valid_o <= '0;
      rsp_drop_o  <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (rsp_valid_i) err_o <= 1'b1;
          if (gnt_hit) begin
            eng_data_o  <= req_arr[gnt_idx];
            eng_port_o  <= gnt_idx;
            last        <= gnt_idx;
            req_ack_o   <= g_num_ports'(1) << gnt_idx;
            eng_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (rsp_valid_i) err_o <= 1'b1;
          if (eng_ready_i) begin
            eng_valid_o <= 1'b0;
            state       <= WAIT_RSP;
`ifdef RTU_ARB_TIMEOUT_EN
            wdog        <= '0;
`endif
          end
        end
        WAIT_RSP: begin
          // A matching response always beats watchdog expiry in the same cycle.
          if (rsp_match) begin
            rsp_data_o  <= rsp_data_i;
            rsp_valid_o <= g_num_ports'(1) << eng_port_o;
            state       <= IDLE;
          end else begin
            if (rsp_valid_i) err_o <= 1'b1;
`ifdef RTU_ARB_TIMEOUT_EN
            if (wdog == EXPIRE) begin
              rsp_data_o  <= '0;
              rsp_valid_o <= g_num_ports'(1) << eng_port_o;
              rsp_drop_o  <= 1'b1;
              state       <= IDLE;
            end else begin
              wdog <= wdog + CW'(1);
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtu_req_arbiter.sv
// Directed self-checking bench for rtu_req_arbiter (7 ports, 112/40-bit payloads).
module tb_rtu_req_arbiter;

  localparam int unsigned N  = 7;
  localparam int unsigned RW = 112;
  localparam int unsigned SW = 40;
  localparam int unsigned PW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic            eng_valid;
  logic [RW-1:0]   eng_data;
  logic [PW-1:0]   eng_port;
  logic            eng_ready;
  logic            rsp_valid_in;
  logic [PW-1:0]   rsp_port;
  logic [SW-1:0]   rsp_data_in;
  logic [N-1:0]    rsp_valid_out;
  logic [SW-1:0]   rsp_data_out;
  logic            rsp_drop;
  logic            err;

  int n_cmp = 0;
  int n_bad = 0;

  rtu_req_arbiter #(
    .g_num_ports(N), .g_req_width(RW), .g_rsp_width(SW), .g_timeout(16)
  ) dut (
    .clk_sys_i   (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ack_o   (req_ack),
    .eng_valid_o (eng_valid),
    .eng_data_o  (eng_data),
    .eng_port_o  (eng_port),
    .eng_ready_i (eng_ready),
    .rsp_valid_i (rsp_valid_in),
    .rsp_port_i  (rsp_port),
    .rsp_data_i  (rsp_data_in),
    .rsp_valid_o (rsp_valid_out),
    .rsp_data_o  (rsp_data_out),
    .rsp_drop_o  (rsp_drop),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    eng_ready    = 1'b0;
    rsp_valid_in = 1'b0;
    rsp_port     = '0;
    rsp_data_in  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    req_valid    = '1;
    req_data     = '1;
    eng_ready    = 1'b1;
    rsp_valid_in = 1'b1;
    rsp_port     = '0;
    rsp_data_in  = '1;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({req_ack, eng_valid, eng_port, rsp_valid_out, rsp_drop, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ack=%h ev=%b port=%0d rv=%h drop=%b err=%b want all 0",
               req_ack, eng_valid, eng_port, rsp_valid_out, rsp_drop, err);
    end
    n_cmp++;
    if (eng_data !== '0 || rsp_data_out !== '0) begin
      n_bad++;
      $display("FAIL reset_data: eng_data=%h rsp_data=%h want 0", eng_data, rsp_data_out);
    end
    do_reset();
  endtask

  task automatic test_single();
    req_valid = 7'h08;
    req_data[3*RW +: RW] = 112'h1234;
    tick();
    n_cmp++;
    if (req_ack !== 7'h08 || eng_valid !== 1'b1 || eng_port !== 3'd3 || eng_data !== 112'h1234) begin
      n_bad++;
      $display("FAIL single_grant: ack=%h ev=%b port=%0d data=%h want 08/1/3/1234",
               req_ack, eng_valid, eng_port, eng_data);
    end
    req_valid = '0;
    eng_ready = 1'b1;
    tick();
    eng_ready = 1'b0;
    n_cmp++;
    if (req_ack !== '0 || eng_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_accept: ack=%h ev=%b want 00/0", req_ack, eng_valid);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rsp_valid_out !== '0) begin
        n_bad++;
        $display("FAIL single_early_rsp: rsp_valid=%h want 00 (wait %0d)", rsp_valid_out, i);
      end
      tick();
    end
    rsp_valid_in = 1'b1;
    rsp_port     = 3'd3;
    rsp_data_in  = 40'hAB_CDEF_0123;
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++;
    if (rsp_valid_out !== 7'h08 || rsp_data_out !== 40'hAB_CDEF_0123 || rsp_drop !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_rsp: rv=%h data=%h drop=%b err=%b want 08/abcdef0123/0/0",
               rsp_valid_out, rsp_data_out, rsp_drop, err);
    end
    tick();
    n_cmp++;
    if (rsp_valid_out !== '0) begin
      n_bad++;
      $display("FAIL single_rsp_pulse: rsp_valid=%h want 00", rsp_valid_out);
    end
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*RW +: RW] = RW'(32'hA000 + i);
    eng_ready = 1'b1;
    req_valid = '1;
    for (int g = 0; g < 8; g++) begin
      exp = g % N;
      tick();
      n_cmp++;
      if (req_ack !== (N'(1) << exp) || eng_port !== PW'(exp) || eng_data !== RW'(32'hA000 + exp)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: ack=%h port=%0d data=%h want port %0d", g, req_ack, eng_port, eng_data, exp);
      end
      tick();
      n_cmp++;
      if (req_ack !== '0 || eng_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_gap%0d: ack=%h ev=%b want 00/0", g, req_ack, eng_valid);
      end
      tick();
      rsp_valid_in = 1'b1;
      rsp_port     = PW'(exp);
      rsp_data_in  = SW'(32'h5500 + exp);
      tick();
      rsp_valid_in = 1'b0;
      if (g == 7) req_valid = '0;
      n_cmp++;
      if (rsp_valid_out !== (N'(1) << exp) || rsp_data_out !== SW'(32'h5500 + exp) || req_ack !== '0) begin
        n_bad++;
        $display("FAIL rr_rsp%0d: rv=%h data=%h ack=%h want port %0d", g, rsp_valid_out, rsp_data_out, req_ack, exp);
      end
    end
    eng_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    req_valid = 7'h04;
    req_data[2*RW +: RW] = 112'hBEEF;
    tick();
    n_cmp++;
    if (req_ack !== 7'h04 || eng_port !== 3'd2 || eng_data !== 112'hBEEF) begin
      n_bad++;
      $display("FAIL bp_grant: ack=%h port=%0d data=%h want 04/2/beef", req_ack, eng_port, eng_data);
    end
    req_data[2*RW +: RW] = 112'hDEAD;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (eng_valid !== 1'b1 || eng_data !== 112'hBEEF || eng_port !== 3'd2 || req_ack !== '0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: ev=%b data=%h port=%0d ack=%h want 1/beef/2/00",
                 i, eng_valid, eng_data, eng_port, req_ack);
      end
    end
    req_valid = '0;
    eng_ready = 1'b1;
    tick();
    eng_ready    = 1'b0;
    rsp_valid_in = 1'b1;
    rsp_port     = 3'd2;
    rsp_data_in  = 40'h22;
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++;
    if (rsp_valid_out !== 7'h04 || rsp_data_out !== 40'h22) begin
      n_bad++;
      $display("FAIL bp_rsp: rv=%h data=%h want 04/22", rsp_valid_out, rsp_data_out);
    end
    tick();
  endtask

  task automatic test_mistag();
    req_valid = 7'h02;
    req_data[1*RW +: RW] = 112'h0101;
    tick();
    n_cmp++;
    if (req_ack !== 7'h02 || eng_port !== 3'd1) begin
      n_bad++;
      $display("FAIL tag_grant: ack=%h port=%0d want 02/1", req_ack, eng_port);
    end
    req_valid = '0;
    eng_ready = 1'b1;
    tick();
    eng_ready    = 1'b0;
    rsp_valid_in = 1'b1;
    rsp_port     = 3'd4;
    rsp_data_in  = 40'h44;
    tick();
    n_cmp++;
    if (err !== 1'b1 || rsp_valid_out !== '0) begin
      n_bad++;
      $display("FAIL tag_bad: err=%b rv=%h want 1/00", err, rsp_valid_out);
    end
    rsp_port    = 3'd1;
    rsp_data_in = 40'h11;
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++;
    if (rsp_valid_out !== 7'h02 || rsp_data_out !== 40'h11 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL tag_good: rv=%h data=%h err=%b want 02/11/0", rsp_valid_out, rsp_data_out, err);
    end
    tick();
  endtask

  task automatic test_stray_rsp();
    rsp_valid_in = 1'b1;
    rsp_port     = 3'd1;
    rsp_data_in  = 40'h99;
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || rsp_valid_out !== '0 || rsp_data_out !== 40'h11) begin
      n_bad++;
      $display("FAIL stray_idle: err=%b rv=%h data=%h want 1/00/11", err, rsp_valid_out, rsp_data_out);
    end
    tick();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_pulse: err=%b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 7'h20;
    req_data[5*RW +: RW] = 112'h5555;
    tick();
    n_cmp++;
    if (req_ack !== 7'h20 || eng_valid !== 1'b1 || eng_port !== 3'd5) begin
      n_bad++;
      $display("FAIL mid_grant: ack=%h ev=%b port=%0d want 20/1/5", req_ack, eng_valid, eng_port);
    end
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    n_cmp++;
    if ({req_ack, eng_valid, eng_port, rsp_valid_out, rsp_drop, err} !== '0 ||
        eng_data !== '0 || rsp_data_out !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: ack=%h ev=%b port=%0d data=%h rv=%h rdata=%h want all 0",
               req_ack, eng_valid, eng_port, eng_data, rsp_valid_out, rsp_data_out);
    end
    rst_n        = 1'b1;
    rsp_valid_in = 1'b1;
    rsp_port     = 3'd5;
    rsp_data_in  = 40'h5;
    tick();
    rsp_valid_in = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || rsp_valid_out !== '0) begin
      n_bad++;
      $display("FAIL mid_late_rsp: err=%b rv=%h want 1/00", err, rsp_valid_out);
    end
    req_valid = 7'h49;
    tick();
    req_valid = '0;
    n_cmp++;
    if (req_ack !== 7'h01 || eng_port !== 3'd0) begin
      n_bad++;
      $display("FAIL mid_prio: ack=%h port=%0d want 01/0", req_ack, eng_port);
    end
    do_reset();
  endtask

`ifdef RTU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      req_valid = 7'h10;
      tick();
      req_valid = '0;
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
        tick();
        n_cmp++;
        if (rsp_valid_out !== '0) begin
          n_bad++;
          $display("FAIL tmo_early%0d: rv=%h want 00 (cycle %0d)", pass, rsp_valid_out, i);
        end
      end
      if (pass == 1) begin
        rsp_valid_in = 1'b1;
        rsp_port     = 3'd4;
        rsp_data_in  = 40'h4444;
      end
      tick();
      rsp_valid_in = 1'b0;
      n_cmp++;
      if (pass == 0 && (rsp_valid_out !== 7'h10 || rsp_drop !== 1'b1 || rsp_data_out !== '0)) begin
        n_bad++;
        $display("FAIL tmo_drop: rv=%h drop=%b data=%h want 10/1/0", rsp_valid_out, rsp_drop, rsp_data_out);
      end
      if (pass == 1 && (rsp_valid_out !== 7'h10 || rsp_drop !== 1'b0 || rsp_data_out !== 40'h4444)) begin
        n_bad++;
        $display("FAIL tmo_race: rv=%h drop=%b data=%h want 10/0/4444", rsp_valid_out, rsp_drop, rsp_data_out);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mistag();
    test_stray_rsp();
    test_reset_mid();
`ifdef RTU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
